// File: rtl/seq_nbit_div_if.sv
// ---------------------------------------------------------------------------
// seq_nbit_div_if
// Start/done handshake bundle for the sequential restoring divider.
//
// Signals
//   start        master -> slave  request, sampled by the divider only in IDLE
//   dividend     master -> slave  unsigned dividend, sampled with start
//   divisor      master -> slave  unsigned divisor, sampled with start
//   busy         slave -> master  high whenever the divider is not idle
//   done         slave -> master  one-cycle completion pulse
//   quotient     slave -> master  registered unsigned quotient
//   remainder    slave -> master  registered unsigned remainder
//   div_by_zero  slave -> master  set together with done for a zero divisor
// ---------------------------------------------------------------------------
interface seq_nbit_div_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface : seq_nbit_div_if

// File: rtl/seq_nbit_div.sv
// ---------------------------------------------------------------------------
// seq_nbit_div
// Sequential radix-2 restoring divider: one quotient bit per clock for two
// unsigned WIDTH-bit operands. The trial subtraction is done by a WIDTH+1 bit
// carry-lookahead adder (cla_nbit) fed with the inverted divisor and cin=1.
//
// Ports
//   i_clk   single clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     seq_nbit_div_if.slave handshake (start/operands in,
//           busy/done/quotient/remainder/div_by_zero out)
//
// Also contains cla_nbit, an N-bit parallel-prefix (Kogge-Stone) adder.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla_nbit
// N-bit carry-lookahead adder: o_sum = i_a + i_b + i_cin, o_cout = carry out.
//
// Ports
//   i_a, i_b  N-bit addends
//   i_cin     carry in
//   o_sum     N-bit sum
//   o_cout    carry out of the MSB
// ---------------------------------------------------------------------------
module cla_nbit #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N-1:0] w_p0;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_gn;
    logic [N-1:0] w_pn;
    logic [N:0]   w_c;

    // Parallel-prefix generate/propagate tree, then per-bit carries and sum.
    always_comb begin
        w_p0 = i_a ^ i_b;
        w_g  = i_a & i_b;
        w_p  = w_p0;
        w_gn = w_g;
        w_pn = w_p;
        // After all levels, w_g[i]/w_p[i] cover the whole group [i:0].
        for (int lv = 0; (1 << lv) < N; lv++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = (1 << lv); i < N; i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lv)]);
                w_pn[i] = w_p[i] & w_p[i - (1 << lv)];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        w_c[0] = i_cin;
        for (int i = 0; i < N; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & i_cin);
        end
        o_sum  = w_p0 ^ w_c[N-1:0];
        o_cout = w_c[N];
    end
endmodule : cla_nbit

module seq_nbit_div #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    seq_nbit_div_if.slave  bus
);
    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Working registers: partial remainder P, shifting dividend/quotient Q.
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;

    // Registered outputs.
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    // FSM decisions.
    logic             w_accept;
    logic             w_zero;
    logic             w_last;

    // Iteration datapath.
    logic [WIDTH:0]   w_shift_p;
    logic [WIDTH:0]   w_t;
    logic             w_unused_cout;
    logic             w_neg;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_q_next;

    // {P,Q} << 1 exposes the next dividend bit at the bottom of P.
    assign w_shift_p = {r_p, r_q[WIDTH-1]};

    cla_nbit #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a    (w_shift_p),
        .i_b    (~{1'b0, r_div}),
        .i_cin  (1'b1),
        .o_sum  (w_t),
        .o_cout (w_unused_cout)
    );

    // Shifted P is always < 2*divisor, so the WIDTH+1 bit MSB is a clean sign.
    assign w_neg    = w_t[WIDTH];
    assign w_p_next = w_neg ? w_shift_p[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], ~w_neg};

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        w_zero      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_CALC;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Iteration registers: load on accept, shift/subtract once per CALC edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p   <= {WIDTH{1'b0}};
            r_q   <= {WIDTH{1'b0}};
            r_div <= {WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_p   <= {WIDTH{1'b0}};
            r_q   <= bus.dividend;
            r_div <= bus.divisor;
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_CALC) begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_cnt <= w_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end else begin
            r_p   <= r_p;
            r_q   <= r_q;
            r_div <= r_div;
            r_cnt <= r_cnt;
        end
    end

    // Status and result registers; results hold until the next completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= {WIDTH{1'b0}};
            r_remainder   <= {WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
        end else begin
            // Tracking the next state keeps busy/done aligned with the FSM.
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
            if (w_zero) begin
                r_quotient    <= {WIDTH{1'b1}};
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end else if (w_last) begin
                r_quotient    <= w_q_next;
                r_remainder   <= w_p_next;
                r_div_by_zero <= 1'b0;
            end else begin
                r_quotient    <= r_quotient;
                r_remainder   <= r_remainder;
                r_div_by_zero <= r_div_by_zero;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule : seq_nbit_div
